// File: rtl/wheel_encoder_array.sv
// Multi-channel quadrature decoder: sync + glitch filter, 4x decode, index homing, error flags.
// Define WHEEL_ENC_VELOCITY_EN to build the shared windowed velocity measurement.
`timescale 1ns/1ps
module wheel_encoder_array #(
  parameter int SYSCLK_FREQ       = 100_000_000,
  parameter int NUM_CH            = 4,
  parameter int COUNTS_PER_REV    = 8192,
  parameter int COUNT_SIZE        = $clog2(COUNTS_PER_REV),
  parameter int FILTER_LEN        = 4,
  parameter int VEL_WINDOW_CYCLES = 1_000_000,
  parameter int VEL_SIZE          = 16
) (
  input  logic                                 sclk,
  input  logic                                 rst,
  input  logic [NUM_CH-1:0]                    enc_a,
  input  logic [NUM_CH-1:0]                    enc_b,
  input  logic [NUM_CH-1:0]                    enc_i,
  input  logic                                 home,
  input  logic                                 err_clr,
  output logic [NUM_CH-1:0][COUNT_SIZE-1:0]    count,
  output logic [NUM_CH-1:0]                    homed,
  output logic [NUM_CH-1:0]                    err,
  output logic signed [NUM_CH-1:0][VEL_SIZE-1:0] velocity,
  output logic                                 vel_valid
);

  localparam int NP = 3 * NUM_CH;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FL = FW'(FILTER_LEN);
  localparam logic [COUNT_SIZE-1:0] CMAX = COUNT_SIZE'(COUNTS_PER_REV - 1);

  if (NUM_CH < 1 || NUM_CH > 8 || FILTER_LEN < 1 || FILTER_LEN > 16 ||
      VEL_WINDOW_CYCLES < 2 || VEL_SIZE < 2 || SYSCLK_FREQ < 1) begin : g_bad_param
    $error("wheel_encoder_array: parameter out of range");
  end

  function automatic logic [1:0] next_ab(input logic [1:0] ab);
    case (ab)
      2'b00:   next_ab = 2'b10;
      2'b10:   next_ab = 2'b11;
      2'b11:   next_ab = 2'b01;
      default: next_ab = 2'b00;
    endcase
  endfunction

  logic [NP-1:0]     raw, sync1, sync2, filt, filt_ok;
  logic [1:0]        fill;
  logic [NUM_CH-1:0] step_fwd, step_rev;

  assign raw = {enc_i, enc_b, enc_a};

  // fill counts the cycles needed to flush reset values out of the synchroniser
  always_ff @(posedge sclk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      fill  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (fill != 2'd2) fill <= fill + 2'd1;
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_filt
    logic [FW-1:0] run_q, run;
    logic          sd_q, fv_q, ok_q;

    always_comb begin
      if (run_q == '0 || sync2[p] != sd_q) run = FW'(1);
      else if (run_q == FL)                run = FL;
      else                                 run = run_q + FW'(1);
    end

    always_ff @(posedge sclk) begin
      if (rst) begin
        run_q <= '0;
        sd_q  <= 1'b0;
        fv_q  <= 1'b0;
        ok_q  <= 1'b0;
      end else begin
        sd_q <= sync2[p];
        if (fill == 2'd2) begin
          run_q <= run;
          if (run == FL) begin
            fv_q <= sync2[p];
            ok_q <= 1'b1;
          end
        end
      end
    end

    assign filt[p]    = fv_q;
    assign filt_ok[p] = ok_q;
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [1:0]            cur, prev_q;
    logic                  primed_q, idx_d_q, idx_ok_q, armed_q, homed_q, err_q;
    logic                  fwd, rev, bad, idx_edge, zero;
    logic [COUNT_SIZE-1:0] cnt_q;

    assign cur      = {filt[n], filt[NUM_CH+n]};
    assign idx_edge = idx_ok_q & filt[2*NUM_CH+n] & ~idx_d_q;
    // home in the same cycle as an index edge arms instead of zeroing
    assign zero     = !home && armed_q && idx_edge;

    always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      bad = 1'b0;
      if (primed_q && cur != prev_q) begin
        if ((cur ^ prev_q) == 2'b11)   bad = 1'b1;
        else if (cur == next_ab(prev_q)) fwd = 1'b1;
        else                           rev = 1'b1;
      end
    end

    always_ff @(posedge sclk) begin
      if (rst) begin
        prev_q   <= '0;
        primed_q <= 1'b0;
        idx_d_q  <= 1'b0;
        idx_ok_q <= 1'b0;
        armed_q  <= 1'b0;
        homed_q  <= 1'b0;
        err_q    <= 1'b0;
        cnt_q    <= '0;
      end else begin
        idx_ok_q <= filt_ok[2*NUM_CH+n];
        idx_d_q  <= filt[2*NUM_CH+n];
        if (filt_ok[n] && filt_ok[NUM_CH+n]) begin
          prev_q   <= cur;
          primed_q <= 1'b1;
        end
        if (bad)          err_q <= 1'b1;
        else if (err_clr) err_q <= 1'b0;
        if (home) begin
          armed_q <= 1'b1;
          homed_q <= 1'b0;
        end else if (zero) begin
          armed_q <= 1'b0;
          homed_q <= 1'b1;
        end
        if (zero)     cnt_q <= '0;
        else if (fwd) cnt_q <= (cnt_q == CMAX) ? '0 : cnt_q + COUNT_SIZE'(1);
        else if (rev) cnt_q <= (cnt_q == '0) ? CMAX : cnt_q - COUNT_SIZE'(1);
      end
    end

    assign count[n]    = cnt_q;
    assign homed[n]    = homed_q;
    assign err[n]      = err_q;
    assign step_fwd[n] = fwd;
    assign step_rev[n] = rev;
  end

`ifdef WHEEL_ENC_VELOCITY_EN
  localparam int WW  = $clog2(VEL_WINDOW_CYCLES);
  localparam int AW0 = $clog2(VEL_WINDOW_CYCLES + 1) + 1;
  localparam int AW  = (AW0 > VEL_SIZE) ? AW0 : VEL_SIZE + 1;
  localparam logic [WW-1:0] WLAST = WW'(VEL_WINDOW_CYCLES - 1);
  localparam logic signed [AW-1:0] VMAX = {{(AW-VEL_SIZE+1){1'b0}}, {(VEL_SIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] VMIN = {{(AW-VEL_SIZE+1){1'b1}}, {(VEL_SIZE-1){1'b0}}};

  logic [WW-1:0] win_q;
  logic          win_last;

  assign win_last = (win_q == WLAST);

  always_ff @(posedge sclk) begin
    if (rst) begin
      win_q     <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= win_last;
      win_q     <= win_last ? '0 : win_q + WW'(1);
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_vel
    logic signed [AW-1:0] acc_q, acc_sum;
    logic [VEL_SIZE-1:0]  vel_q, vel_sat;

    // accumulator sees raw steps, so homing and wrap leave it untouched
    always_comb begin
      acc_sum = acc_q + (step_fwd[n] ? AW'(1) : (step_rev[n] ? {AW{1'b1}} : '0));
      if (acc_sum > VMAX)      vel_sat = VMAX[VEL_SIZE-1:0];
      else if (acc_sum < VMIN) vel_sat = VMIN[VEL_SIZE-1:0];
      else                     vel_sat = acc_sum[VEL_SIZE-1:0];
    end

    always_ff @(posedge sclk) begin
      if (rst) begin
        acc_q <= '0;
        vel_q <= '0;
      end else if (win_last) begin
        acc_q <= '0;
        vel_q <= vel_sat;
      end else begin
        acc_q <= acc_sum;
      end
    end

    assign velocity[n] = vel_q;
  end
`else
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_wheel_encoder_array.sv
// Bench for wheel_encoder_array: vector table, hand-written corner sequences,
// random quadrature walk against a position model, velocity scoreboard.
`timescale 1ns/1ps
module tb_wheel_encoder_array;

  localparam int NCH = 4;
  localparam int CPR = 8192;
  localparam int CS  = 13;
  localparam int FL  = 4;
  localparam int WIN = 1000;
  localparam int LAT = 2 + FL + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0] enc_a, enc_b, enc_i;
  logic           home, err_clr;
  logic [NCH-1:0][CS-1:0]        cnt_o, cnt_s;
  logic [NCH-1:0]                homed_o, err_o, homed_s, err_s;
  logic signed [NCH-1:0][15:0]   vel_o;
  logic signed [NCH-1:0][3:0]    vel_s;
  logic                          vv_o, vv_s;

  wheel_encoder_array #(
    .NUM_CH(NCH), .COUNTS_PER_REV(CPR), .FILTER_LEN(FL),
    .VEL_WINDOW_CYCLES(WIN), .VEL_SIZE(16)
  ) dut (
    .sclk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
    .home(home), .err_clr(err_clr), .count(cnt_o), .homed(homed_o),
    .err(err_o), .velocity(vel_o), .vel_valid(vv_o)
  );

  wheel_encoder_array #(
    .NUM_CH(NCH), .COUNTS_PER_REV(CPR), .FILTER_LEN(FL),
    .VEL_WINDOW_CYCLES(WIN), .VEL_SIZE(4)
  ) dut_s (
    .sclk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
    .home(home), .err_clr(err_clr), .count(cnt_s), .homed(homed_s),
    .err(err_s), .velocity(vel_s), .vel_valid(vv_s)
  );

  // scoreboard / model state
  int checks = 0;
  int errors = 0;
  int pos[NCH];
  int kst[NCH];
  logic [15:0] exp_q[$];

  typedef struct {
    int ch;
    int dir;
    int n;
    int gap;
    int exp_cnt;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_count(input int ch);
    return ((pos[ch] % CPR) + CPR) % CPR;
  endfunction

  function automatic logic [1:0] gray(input int k);
    case (k & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input int ch);
    {enc_a[ch], enc_b[ch]} = gray(kst[ch]);
  endtask

  task automatic step_now(input int ch, input int dir);
    kst[ch] = (kst[ch] + dir) & 3;
    pos[ch] = pos[ch] + dir;
    apply(ch);
  endtask

  task automatic do_step(input int ch, input int dir, input int gap);
    step_now(ch, dir);
    tick(gap);
  endtask

  task automatic chk_all(input string tag);
    for (int n = 0; n < NCH; n++) begin
      chk($sformatf("%s count[%0d]", tag, n), int'(cnt_o[n]), exp_count(n));
      chk($sformatf("%s count_s[%0d]", tag, n), int'(cnt_s[n]), exp_count(n));
    end
  endtask

  task automatic run_vel(input int period, input int dir, input int nwin,
                         input int exp16, input int exp4);
    int cyc, seen, last;
    cyc = 0; seen = 0; last = 0;
    for (int i = 0; i < nwin; i++) exp_q.push_back(16'(exp16));
    tick(25);
    while (seen <= nwin && cyc < (nwin + 2) * WIN) begin
      if (cyc % period == 0) step_now(0, dir);
      tick(1);
      cyc++;
      if (vv_o) begin
        if (seen > 0) begin
          chk("velocity16", int'($signed(vel_o[0])), int'($signed(exp_q.pop_front())));
          chk("velocity4_sat", int'($signed(vel_s[0])), exp4);
          chk("vel_spacing", cyc - last, WIN);
          chk("vel_valid_s", int'(vv_s), 1);
        end
        last = cyc;
        seen++;
      end
    end
    if (seen <= nwin) begin
      checks++;
      errors++;
      $display("FAIL vel_timeout: got %0d strobes, required %0d", seen, nwin + 1);
      exp_q.delete();
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cyc;
    bit got;
    rst = 1'b1; enc_a = '0; enc_b = '0; enc_i = '0; home = 1'b0; err_clr = 1'b0;
    for (int n = 0; n < NCH; n++) begin pos[n] = 0; kst[n] = 0; end
    tbl[0] = '{ch: 0, dir:  1, n: 99,  gap: 20, exp_cnt: 100};
    tbl[1] = '{ch: 1, dir: -1, n: 3,   gap: 20, exp_cnt: 8189};
    tbl[2] = '{ch: 1, dir:  1, n: 5,   gap: 20, exp_cnt: 2};
    tbl[3] = '{ch: 3, dir:  1, n: 500, gap: 8,  exp_cnt: 500};
    tbl[4] = '{ch: 2, dir:  1, n: 7,   gap: 20, exp_cnt: 7};
    tbl[5] = '{ch: 2, dir: -1, n: 2,   gap: 20, exp_cnt: 5};

    tick(3);
    chk("reset count", int'(cnt_o), 0);
    chk("reset homed", int'(homed_o), 0);
    chk("reset err", int'(err_o), 0);
    chk("reset velocity", int'(vel_o != '0), 0);
    chk("reset vel_valid", int'(vv_o), 0);
    rst = 1'b0;
    tick(12);
    chk("primed no count", int'(cnt_o), 0);

    // first step: exact pin-to-count latency
    step_now(0, 1);
    tick(LAT - 1);
    chk("latency before", int'(cnt_o[0]), 0);
    tick(1);
    chk("latency after", int'(cnt_o[0]), 1);
    tick(15);

    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < tbl[r].n; s++) do_step(tbl[r].ch, tbl[r].dir, tbl[r].gap);
      tick(LAT + 2);
      chk($sformatf("vec%0d count", r), int'(cnt_o[tbl[r].ch]), tbl[r].exp_cnt);
      chk_all($sformatf("vec%0d model", r));
      chk($sformatf("vec%0d err", r), int'(err_o), 0);
    end

    // glitch shorter than the filter on ch2 (A currently 1)
    enc_a[2] = 1'b0; tick(3); enc_a[2] = 1'b1; tick(15);
    chk("glitch count", int'(cnt_o[2]), 5);
    chk("glitch err", int'(err_o), 0);

    // illegal transition 10 -> 01
    kst[2] = 3; apply(2); tick(LAT + 2);
    chk("illegal err", int'(err_o), 4'b0100);
    chk("illegal count held", int'(cnt_o[2]), 5);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("err_clr", int'(err_o), 0);

    // illegal transition 01 -> 10 with err_clr on the same cycle: set wins
    kst[2] = 1; apply(2); tick(LAT - 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("err set wins", int'(err_o), 4'b0100);
    chk("err set wins count", int'(cnt_o[2]), 5);
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    chk("err_clr again", int'(err_o), 0);

    // homing on ch3
    enc_i[3] = 1'b1; tick(15);
    chk("index unarmed count", int'(cnt_o[3]), 500);
    chk("index unarmed homed", int'(homed_o), 0);
    enc_i[3] = 1'b0; tick(15);
    home = 1'b1; tick(1); home = 1'b0; tick(3);
    enc_i[3] = 1'b1; tick(LAT - 1);
    chk("home before", int'(cnt_o[3]), 500);
    tick(1);
    chk("home zero", int'(cnt_o[3]), 0);
    chk("home homed", int'(homed_o), 4'b1000);
    pos[3] = 0;
    tick(10); enc_i[3] = 1'b0; tick(10);
    for (int s = 0; s < 3; s++) do_step(3, 1, 20);
    tick(10);
    enc_i[3] = 1'b1; tick(15); enc_i[3] = 1'b0; tick(15);
    chk("second index count", int'(cnt_o[3]), 3);
    chk("second index homed", int'(homed_o), 4'b1000);
    home = 1'b1; tick(1); home = 1'b0;
    chk("rehome clears homed", int'(homed_o), 0);
    enc_i[3] = 1'b1; tick(LAT - 1);
    home = 1'b1; tick(1); home = 1'b0; tick(10);
    chk("home+index count", int'(cnt_o[3]), 3);
    chk("home+index homed", int'(homed_o), 0);
    enc_i[3] = 1'b0; tick(15);
    enc_i[3] = 1'b1; tick(LAT);
    chk("rearmed zero", int'(cnt_o[3]), 0);
    chk("rearmed homed", int'(homed_o), 4'b1000);
    pos[3] = 0;
    enc_i[3] = 1'b0; tick(15);

    // random quadrature walk
    for (int i = 0; i < 60; i++) begin
      do_step(int'($urandom_range(0, NCH - 1)), ($urandom_range(0, 1) != 0) ? 1 : -1,
              int'($urandom_range(6, 15)));
      if (i % 15 == 14) begin
        tick(LAT + 2);
        chk_all($sformatf("rand%0d", i));
      end
    end
    chk("rand err", int'(err_o), 0);

`ifdef WHEEL_ENC_VELOCITY_EN
    run_vel(20, 1, 3, 50, 7);
    run_vel(100, 1, 2, 10, 7);
    run_vel(100, -1, 2, -10, -8);
    tick(LAT + 2);
    chk_all("after velocity");
    chk("velocity err", int'(err_o), 0);
`else
    tick(WIN + 10);
    chk("velocity tied", int'(vel_o != '0), 0);
    chk("vel_valid tied", int'(vv_o), 0);
`endif

    // mid-run reset with ch0 resting on a non-00 state and a step in flight
    while (kst[0] != 2) do_step(0, 1, 20);
    step_now(0, 1);
    tick(2);
    rst = 1'b1; tick(1);
    chk("midreset count", int'(cnt_o != '0), 0);
    chk("midreset homed", int'(homed_o), 0);
    chk("midreset err", int'(err_o), 0);
    chk("midreset velocity", int'(vel_o != '0), 0);
    chk("midreset vel_valid", int'(vv_o), 0);
    chk("midreset homed_s", int'(homed_s | err_s), 0);
    rst = 1'b0;
    for (int n = 0; n < NCH; n++) pos[n] = 0;
    n_cyc = 0; got = 1'b0;
    while (n_cyc < 1200 && !got) begin
      tick(1);
      n_cyc++;
      if (n_cyc == 40) begin
        chk_all("reprime");
        chk("reprime err", int'(err_o), 0);
      end
`ifdef WHEEL_ENC_VELOCITY_EN
      if (vv_o) got = 1'b1;
`else
      if (n_cyc >= 40) got = 1'b1;
`endif
    end
`ifdef WHEEL_ENC_VELOCITY_EN
    chk("first strobe cycle", n_cyc, WIN);
    chk("first strobe velocity", int'($signed(vel_o[0])), 0);
`endif
    do_step(0, 1, 20);
    do_step(0, 1, 20);
    tick(LAT + 2);
    chk("post reset count", int'(cnt_o[0]), 2);
    chk_all("final");
    chk("final err", int'(err_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wheel_encoder_array.md
# wheel_encoder_array

Parametrised multi-channel quadrature decoder. It is the next-generation replacement for the per-wheel decoder instances in the wheel-encoder/GPS wrapper. Each channel provides:
- input synchronisation and glitch filtering;
- 4x decoding into a wrapping position count;
- index-based homing with per-channel status;
- illegal-transition detection.

An optional windowed velocity measurement, common to all channels, feeds the drive control loop.

## Interface
Parameters:
- `SYSCLK_FREQ`, 100_000_000: system clock in Hz. Documentation only; not used in the logic.
- `NUM_CH`, 4: number of encoder channels, 1 to 8.
- `COUNTS_PER_REV`, 8192: counts per revolution, after 4x decoding.
- `COUNT_SIZE`, `$clog2(COUNTS_PER_REV)`: width of the position count.
- `FILTER_LEN`, 4: number of consecutive stable cycles a synchronised input must hold before it is accepted. Range 1 to 16.
- `VEL_WINDOW_CYCLES`, 1_000_000: length of the velocity sample window in cycles (10 ms at 100 MHz). Minimum 2.
- `VEL_SIZE`, 16: width of the signed velocity output.

Ports (clock and reset first):
- `sclk`  in  1: system clock. This is the only clock in the block.
- `rst`  in  1: synchronous, active-high reset.
- `enc_a`, `enc_b`, `enc_i`  in  `NUM_CH`: raw asynchronous encoder A, B and index pins. Bit n belongs to channel n.
- `home`  in  1: single-cycle pulse that arms index homing on all channels.
- `err_clr`  in  1: single-cycle pulse that clears all error flags.
- `count`  out  `[COUNT_SIZE-1:0] [NUM_CH-1:0]`: position count per channel.
- `homed`  out  `NUM_CH`: set when a channel has been zeroed by its index pulse.
- `err`  out  `NUM_CH`: sticky illegal-transition flag per channel.
- `velocity`  out  signed `[VEL_SIZE-1:0] [NUM_CH-1:0]`: counts per window.
- `vel_valid`  out  1: one-cycle strobe that marks a new `velocity` value.

## Operation
- **Input path**
  - Each pin passes through a 2-FF synchroniser, then a stability filter.
  - The filter counter resets whenever the synchronised value differs from the previous cycle's value.
  - The filtered value takes the synchronised value once that value has held for `FILTER_LEN` consecutive cycles.
  - With `FILTER_LEN`=1, the filter is a single register.
- **Priming**
  - After reset, each channel's decoder primes itself on the first cycle after its filter is valid (2+`FILTER_LEN` cycles).
  - On that cycle it loads its previous-state register from the filtered A/B.
  - Priming produces no count change and sets no error.
- **Decoding**
  - Previous and current filtered {A,B} are compared each cycle.
  - +1 on 00→10, 10→11, 11→01, 01→00 (A leads B).
  - −1 on the reverse transitions.
  - No change if the state is unchanged.
  - If both bits change in one cycle: the count is held and `err[n]` is set.
- **Wrap**: +1 at `COUNTS_PER_REV`−1 gives 0. −1 at 0 gives `COUNTS_PER_REV`−1.
- **Homing**
  - `home` sets `armed[n]` for every channel.
  - While `armed[n]` is set, a rising edge of the filtered index forces `count[n]`=0, sets `homed[n]` and clears `armed[n]`.
  - The zeroing overrides any step in the same cycle.
  - If `home` and an index edge occur in the same cycle, the channel arms and that index edge is ignored.
  - `home` while already homed clears `homed[n]` and re-arms the channel.
- **Errors**: `err[n]` is sticky. `err_clr` clears all bits. If an error is set and cleared in the same cycle, the set wins.
- **Velocity** (only when the macro is defined)
  - A shared window counter runs from 0 to `VEL_WINDOW_CYCLES`−1.
  - Each channel keeps a signed step accumulator.
  - Homing and wrap do not affect the accumulator.
  - On the last cycle of a window: `velocity[n]` gets the accumulator value including that cycle's step, saturated to the `VEL_SIZE` signed range. The accumulator restarts at 0, and `vel_valid` pulses.

## Timing
- **Reset values**: `count`=0, `homed`=0, `err`=0, `velocity`=0, `vel_valid`=0. `armed`, the filters, the priming flags and the window counter are cleared.
- **Pin-to-count latency**: 2 (synchroniser) + `FILTER_LEN` (filter) + 1 (decode register) cycles after the pin change is first sampled. This is 7 cycles at the default `FILTER_LEN`.
- **Index zeroing**: same latency as a step, measured from the index rising edge.
- **`vel_valid`**: first strobe on cycle `VEL_WINDOW_CYCLES` after reset is released, then every `VEL_WINDOW_CYCLES` cycles. `velocity` is stable between strobes.
- **Rate limit**: maximum trackable edge rate is one filtered A/B state change per `FILTER_LEN`+1 cycles per channel. Faster input produces `err` or lost counts; that is accepted behaviour.
- **Reset mid-operation**: all state returns to reset values within one cycle, and the channels re-prime.

## Configuration
- `WHEEL_ENC_VELOCITY_EN` defined: window counter, accumulators, saturation and the `velocity`/`vel_valid` outputs are built.
- Not defined: that logic is omitted, `velocity` is tied to 0 and `vel_valid` is tied to 0. Position, homing and error behaviour are unchanged.

## Test plan
Bench configuration: `NUM_CH`=4, `COUNTS_PER_REV`=8192, `FILTER_LEN`=4, `VEL_WINDOW_CYCLES`=1000, macro defined.

- **Forward count**: 100 forward quadrature steps on ch0, 20 cycles per state → `count[0]`=100, other channels 0, `err`=0.
- **Wrap**: 3 reverse steps on ch1 from reset → `count[1]`=8189. Then 5 forward steps → `count[1]`=2.
- **Glitch and illegal transition**: 3-cycle pulse on `enc_a[2]` → no count change. Simultaneous A/B toggle on ch2 → `err[2]`=1 and count held. `err_clr` → `err[2]`=0.
- **Homing**
  - With `count[3]`=500, an index edge without `home` → no change.
  - `home` pulse, then an index edge → `count[3]`=0 and `homed[3]`=1 at 7 cycles latency.
  - A second index edge → no effect.
- **Velocity**
  - ch0 stepping +1 every 20 cycles → `velocity[0]`=50 at each `vel_valid`, spaced 1000 cycles apart.
  - With `VEL_SIZE`=4 and 10 steps per window → `velocity`=7 (saturated).
- **Mid-run reset**: assert `rst` for 1 cycle while stepping → all outputs 0 the next cycle. The first state seen after priming produces no count change and no error.
